// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 frame receiver: error codes, FSM state
// encoding and frame geometry.
package ps2_pkg;

   localparam int DATA_BITS = 8;

   localparam logic [1:0] ERR_PARITY   = 2'd0;
   localparam logic [1:0] ERR_STOP     = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
   localparam logic [1:0] ERR_OVERFLOW = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_t;

   // Odd parity holds when data and parity bit together carry an odd number of ones
   function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] data,
                                          input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// PS/2 clock conditioning: 2-FF synchroniser, run-length glitch filter and
// falling-edge detector. The filtered level only follows the synced pin after
// FILTER_LEN identical consecutive samples; fall pulses on the cycle after
// the filtered level drops.
module ps2_sync_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic pin,
   output logic fall
);

   localparam int CW = $clog2(FILTER_LEN + 1);

   logic          sync_p0;
   logic          sync_p1;
   logic          filt;
   logic [CW-1:0] run_cnt;

   // Two-flop synchroniser; idle bus level is high
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync_p0 <= 1'b1;
         sync_p1 <= 1'b1;
      end else begin
         sync_p0 <= pin;
         sync_p1 <= sync_p0;
      end
   end

   // Count samples that disagree with the filtered level; flip once the run is long enough
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         filt    <= 1'b1;
         run_cnt <= '0;
         fall    <= 1'b0;
      end else begin
         fall <= 1'b0;
         if (sync_p1 == filt) begin
            run_cnt <= '0;
         end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
            filt    <= sync_p1;
            run_cnt <= '0;
            fall    <= ~sync_p1;
         end else begin
            run_cnt <= run_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver. Deserialises start / 8 data (LSB first)
// / odd parity / stop frames on filtered PS2Clk falling edges and hands good
// bytes to the keyboard driver. Optional output FIFO with ready/valid
// handshake is enabled by defining PS2_RX_FIFO_EN.
module ps2_rx_frame
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 20000,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   input  logic                 PS2Clk,
   input  logic                 PS2Data,
   output logic [DATA_BITS-1:0] code,
   output logic                 code_valid,
   input  logic                 code_ready,
   output logic                 frame_err,
   output logic [1:0]           err_kind,
   output logic                 busy
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int BW = $clog2(DATA_BITS);

   logic                 dsync_p0;
   logic                 dsync_p1;
   logic                 fall_p0;

   ps2_state_t           state;
   logic [BW-1:0]        bitcnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit;
   logic [TW-1:0]        tocnt;

   logic                 vld_p1;
   logic [DATA_BITS-1:0] byte_p1;
   logic                 ovf_evt;

   ps2_sync_filter #(
      .FILTER_LEN (FILTER_LEN)
   ) u_clk_filter (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .pin       (PS2Clk),
      .fall      (fall_p0)
   );

   // Data pin is only synchronised; it is sampled when the filtered clock falls
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         dsync_p0 <= 1'b1;
         dsync_p1 <= 1'b1;
      end else begin
         dsync_p0 <= PS2Data;
         dsync_p1 <= dsync_p0;
      end
   end

   // Frame FSM with timeout supervision; byte and error reporting are registered here
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= ST_IDLE;
         bitcnt    <= '0;
         shreg     <= '0;
         par_bit   <= 1'b0;
         tocnt     <= '0;
         vld_p1    <= 1'b0;
         byte_p1   <= '0;
         frame_err <= 1'b0;
         err_kind  <= ERR_PARITY;
      end else begin
         vld_p1    <= 1'b0;
         frame_err <= 1'b0;

         if (state == ST_IDLE || fall_p0) begin
            tocnt <= '0;
         end else if (tocnt != TW'(TIMEOUT_CYC)) begin
            tocnt <= tocnt + 1'b1;
         end

         if (fall_p0) begin
            case (state)
               ST_IDLE: begin
                  // A high bit here is line noise, not a start bit
                  if (!dsync_p1) begin
                     state  <= ST_DATA;
                     bitcnt <= '0;
                  end
               end
               ST_DATA: begin
                  shreg[bitcnt] <= dsync_p1;
                  if (bitcnt == BW'(DATA_BITS - 1)) begin
                     state <= ST_PARITY;
                  end else begin
                     bitcnt <= bitcnt + 1'b1;
                  end
               end
               ST_PARITY: begin
                  par_bit <= dsync_p1;
                  state   <= ST_STOP;
               end
               ST_STOP: begin
                  state <= ST_IDLE;
                  // Parity failure is reported in preference to a bad stop bit
                  if (!odd_parity_ok(shreg, par_bit)) begin
                     frame_err <= 1'b1;
                     err_kind  <= ERR_PARITY;
                  end else if (!dsync_p1) begin
                     frame_err <= 1'b1;
                     err_kind  <= ERR_STOP;
                  end else begin
                     vld_p1  <= 1'b1;
                     byte_p1 <= shreg;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end else if (state != ST_IDLE && tocnt == TW'(TIMEOUT_CYC)) begin
            state     <= ST_IDLE;
            frame_err <= 1'b1;
            err_kind  <= ERR_TIMEOUT;
         end

         // Overflow is flagged one cycle after a stop edge, so it never collides with a frame error
         if (ovf_evt) begin
            frame_err <= 1'b1;
            err_kind  <= ERR_OVERFLOW;
         end
      end
   end

   assign busy = (state != ST_IDLE);

`ifdef PS2_RX_FIFO_EN
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [AW:0]          count;
   logic                 full;
   logic                 pop;
   logic                 push_ok;

   assign full       = (count == (AW + 1)'(FIFO_DEPTH));
   assign code_valid = (count != '0);
   assign code       = mem[rd_ptr];
   assign pop        = code_valid && code_ready;
   // A simultaneous pop frees a slot, so a push into a full FIFO still lands
   assign push_ok    = vld_p1 && (!full || pop);
   assign ovf_evt    = vld_p1 && full && !pop;

   // Output FIFO: pointers wrap naturally because the depth is a power of two
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= byte_p1;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
`else
   logic unused_ok;

   assign code       = byte_p1;
   assign code_valid = vld_p1;
   assign ovf_evt    = 1'b0;
   assign unused_ok  = code_ready ^ FIFO_DEPTH[0];
`endif

endmodule

// File: doc/ps2_rx_frame.md
Name: ps2_rx_frame

Overview:
- PS/2 device-to-host frame receiver. Sits directly upstream of the keyboard driver and feeds it raw scan-code bytes.
- Synchronises and deglitches PS2Clk/PS2Data, then deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop).
- Outputs validated bytes with a valid strobe and flags framing errors; the keyboard driver handles make/break decoding, modifiers and ASCII mapping.

Parameters:
- FILTER_LEN, 8, consecutive identical sys_clk samples needed before the filtered PS2Clk changes state.
- TIMEOUT_CYC, 20000, sys_clk cycles without a falling edge mid-frame before abort (200 us at 100 MHz).
- FIFO_DEPTH, 4, output FIFO entries; used only with PS2_RX_FIFO_EN; power of two.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- PS2Clk  in  1  raw PS/2 clock pin, asynchronous.
- PS2Data  in  1  raw PS/2 data pin, asynchronous.
- code  out  8  received scan-code byte.
- code_valid  out  1  code is valid (see handshake).
- code_ready  in  1  consumer accepts code; ignored without PS2_RX_FIFO_EN.
- frame_err  out  1  one-cycle error pulse.
- err_kind  out  2  last error: 0 parity, 1 stop, 2 timeout, 3 overflow.
- busy  out  1  high while the FSM is not in IDLE.

Behaviour:
- Reset is asynchronous, active-low, one clock domain. All outputs reset to 0. Synchroniser and filter registers reset to 1 (idle bus is high). FSM resets to IDLE, bit counter and timeout counter to 0.
- Reset asserted mid-frame discards the partial frame. No valid or error pulse is produced.
- Synchronisation: 2-FF synchroniser on both pins.
- Clock filter: the filtered clock takes the synced value only after FILTER_LEN identical consecutive samples.
- Data is not filtered. It is sampled from the synced pin on the cycle a filtered-clock falling edge is detected.
- Edge-detect latency: 2 + FILTER_LEN cycles from the pin transition.
- FSM states IDLE, DATA, PARITY, STOP. All transitions happen on falling-edge cycles unless stated.
  - IDLE: sampled bit 0 -> DATA, bitcnt=0. Sampled bit 1 -> stay in IDLE silently (noise), no error.
  - DATA: shift the bit into shreg[bitcnt] (LSB first). bitcnt 0..7; after bit 7 -> PARITY.
  - PARITY: latch the parity bit -> STOP.
  - STOP: if stop=1 and XOR(data, parity)=1, emit the byte. Else raise an error: bad parity gives err_kind 0; parity OK with stop=0 gives err_kind 1. Parity takes precedence when both fail. Then -> IDLE.
- Timeout counter:
  - Clears on every falling edge and in IDLE.
  - Saturates at TIMEOUT_CYC.
  - Reaching TIMEOUT_CYC outside IDLE -> IDLE, frame_err with err_kind 2, frame discarded.
- Emission occurs the cycle after the stop-bit edge cycle.
- frame_err pulses 1 cycle. err_kind updates in the same cycle and holds until the next error.
- A good frame never changes err_kind.
- busy = (state != IDLE).

Optional Feature:
- Macro PS2_RX_FIFO_EN.
- Defined:
  - Emitted bytes are pushed into a FIFO_DEPTH-entry FIFO.
  - code = head entry; code_valid = !empty. Pop happens on the cycle code_valid && code_ready.
  - Push while full and no pop in the same cycle: the new byte is dropped, frame_err pulses with err_kind 3.
  - Push while full with a pop in the same cycle succeeds.
  - Push while empty: code_valid rises the cycle after the push (one cycle later than without the FIFO).
- Undefined:
  - code_valid is a single-cycle pulse on emission. code holds the last byte until the next good frame.
  - code_ready is ignored; err_kind 3 never occurs.

Decomposition:
- Package ps2_pkg holds:
  - the err_kind encoding constants (ERR_PARITY, ERR_STOP, ERR_TIMEOUT, ERR_OVERFLOW);
  - the FSM state encoding;
  - the frame constant DATA_BITS=8.
- Sub-module ps2_sync_filter: 2-FF synchroniser, FILTER_LEN filter and falling-edge detect. Instantiated for PS2Clk; data uses its synced output only.

Test Plan:
- Frame 0x1C (bits 0,0,0,1,1,1,0,0,0,0,1: start, LSB-first data, parity 0, stop), 10 kHz bus clock -> code=0x1C, code_valid one cycle; frame_err stays 0 and busy returns 0.
- Frame 0x1C with parity=1 -> frame_err pulse, err_kind=0, no code_valid. A following good frame 0xF0 (parity 1) -> code=0xF0, err_kind still 0.
- Frame 0x1C with stop=0 -> frame_err, err_kind=1, no valid. A 3-cycle low glitch on PS2Clk while idle -> no state change, busy stays 0.
- Clock stops after the 5th bit for TIMEOUT_CYC+10 cycles -> frame_err, err_kind=2, busy falls. Next full frame 0x5A is received correctly.
- sys_rst_n pulsed low after bit 4 -> all outputs 0, no pulses. Next frame 0x29 is received correctly.
- With PS2_RX_FIFO_EN and code_ready=0: frames 0x11, 0x22, 0x33, 0x44, 0x55 -> the 5th sets frame_err with err_kind=3. Then code_ready=1 drains 0x11, 0x22, 0x33, 0x44 in order, and code_valid falls after the 4th pop.
